// File: rtl/vm_pkg.sv
// -----------------------------------------------------------------------------
// vm_pkg
// Shared types and constants for the multi-coin vending-machine controller.
//   - vm_state_e  : controller state encoding (2 bits)
//   - credit_op_e : operation applied to the credit register on the next edge
//   - COIN_*      : coin acceptor codes
//   - coin_value  : maps a coin code to its value in cents
// -----------------------------------------------------------------------------
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } vm_state_e;

    typedef enum logic [1:0] {
        CR_HOLD     = 2'd0,   // keep the current credit
        CR_ADD      = 2'd1,   // credit + coin value
        CR_ADD_VEND = 2'd2,   // credit + coin value - PRICE
        CR_SUB_UNIT = 2'd3    // credit - VAL1 (one change coin paid out)
    } credit_op_e;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_1    = 2'd1;
    localparam logic [1:0] COIN_2    = 2'd2;
    localparam logic [1:0] COIN_3    = 2'd3;

    // Value in cents of a coin code; "none" is worth nothing.
    function automatic int coin_value(input logic [1:0] code, input int v1,
                                      input int v2, input int v3);
        int val;
        case (code)
            COIN_1:  val = v1;
            COIN_2:  val = v2;
            COIN_3:  val = v3;
            default: val = 0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vm_credit.sv
// -----------------------------------------------------------------------------
// vm_credit
// Credit register with its add, add-and-pay-PRICE and pay-one-change-coin paths.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   coin        in   coin code presented this cycle
//   op          in   operation to apply on the next edge
//   credit      out  current credit register value
//   reach_price out  credit + value(coin) >= PRICE
//   credit_zero out  credit register is zero
// -----------------------------------------------------------------------------
module vm_credit
    import vm_pkg::*;
#(
    parameter int PRICE    = 15,
    parameter int VAL1     = 5,
    parameter int VAL2     = 10,
    parameter int VAL3     = 25,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  credit_op_e          op,
    output logic [CREDIT_W-1:0] credit,
    output logic                reach_price,
    output logic                credit_zero
);

    // One extra bit so the comparison against PRICE can never alias.
    localparam int SUM_W = CREDIT_W + 1;

    logic [CREDIT_W-1:0] credit_r;
    logic [CREDIT_W-1:0] credit_nxt_s;
    logic [SUM_W-1:0]    coin_val_s;
    logic [SUM_W-1:0]    sum_s;
    logic [CREDIT_W-1:0] vend_s;
    logic [CREDIT_W-1:0] unit_s;

    // Arithmetic paths: add coin, add coin and pay PRICE, pay one change unit.
    always_comb begin
        coin_val_s = SUM_W'(coin_value(coin, VAL1, VAL2, VAL3));
        sum_s      = {1'b0, credit_r} + coin_val_s;
        // The width constraint keeps the sum below 2^CREDIT_W, so the
        // truncated subtraction is exact.
        vend_s     = sum_s[CREDIT_W-1:0] - CREDIT_W'(PRICE);
        unit_s     = credit_r - CREDIT_W'(VAL1);
    end

    // Select the next credit value from the requested operation.
    always_comb begin
        credit_nxt_s = credit_r;
        case (op)
            CR_HOLD:     credit_nxt_s = credit_r;
            CR_ADD:      credit_nxt_s = sum_s[CREDIT_W-1:0];
            CR_ADD_VEND: credit_nxt_s = vend_s;
            CR_SUB_UNIT: credit_nxt_s = unit_s;
            default:     credit_nxt_s = credit_r;
        endcase
    end

    // Credit register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_r <= {CREDIT_W{1'b0}};
        end else begin
            credit_r <= credit_nxt_s;
        end
    end

    assign credit      = credit_r;
    assign reach_price = (sum_s >= SUM_W'(PRICE));
    assign credit_zero = (credit_r == {CREDIT_W{1'b0}});

endmodule

// File: rtl/vm_multi.sv
// -----------------------------------------------------------------------------
// vm_multi
// Three-denomination vending-machine controller. Accumulates credit, pulses
// dispense when PRICE is reached, returns surplus as a train of VAL1 change
// pulses and refunds all credit on cancel.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   coin        in   coin code: 0 none, 1/2/3 = VAL1/VAL2/VAL3
//   cancel      in   refund request (level)
//   dispense    out  one-cycle item release pulse (registered)
//   change_out  out  one VAL1 coin returned per high cycle (registered)
//   coin_reject out  the coin sampled on the previous edge was refused
//   credit      out  current credit
//   busy        out  high while vending or paying change
// -----------------------------------------------------------------------------
module vm_multi
    import vm_pkg::*;
#(
    parameter int PRICE    = 15,
    parameter int VAL1     = 5,
    parameter int VAL2     = 10,
    parameter int VAL3     = 25,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                dispense,
    output logic                change_out,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int MAX_VAL = (VAL1 > VAL2) ? ((VAL1 > VAL3) ? VAL1 : VAL3)
                                           : ((VAL2 > VAL3) ? VAL2 : VAL3);

    // Largest value the credit path ever holds is (PRICE - VAL1) + MAX_VAL.
    if ((2 ** CREDIT_W) <= (PRICE - VAL1 + MAX_VAL)) begin : g_credit_w_check
        $error("vm_multi: CREDIT_W too narrow for PRICE and coin values");
    end
    if (((PRICE % VAL1) != 0) || ((VAL2 % VAL1) != 0) || ((VAL3 % VAL1) != 0))
    begin : g_unit_check
        $error("vm_multi: PRICE, VAL2 and VAL3 must be multiples of VAL1");
    end

    vm_state_e  state_r;
    vm_state_e  state_nxt_s;
    credit_op_e op_s;
    logic       reach_price_s;
    logic       credit_zero_s;
    logic       coin_valid_s;
    logic       dispense_s;
    logic       change_s;
    logic       reject_s;
    logic       dispense_r;
    logic       change_r;
    logic       reject_r;

    assign coin_valid_s = (coin != COIN_NONE);

    vm_credit #(
        .PRICE    (PRICE),
        .VAL1     (VAL1),
        .VAL2     (VAL2),
        .VAL3     (VAL3),
        .CREDIT_W (CREDIT_W)
    ) u_credit (
        .clk         (clk),
        .reset       (reset),
        .coin        (coin),
        .op          (op_s),
        .credit      (credit),
        .reach_price (reach_price_s),
        .credit_zero (credit_zero_s)
    );

    // State register and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            dispense_r <= 1'b0;
            change_r   <= 1'b0;
            reject_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            dispense_r <= dispense_s;
            change_r   <= change_s;
            reject_r   <= reject_s;
        end
    end

    // Next-state and credit-operation decode.
    always_comb begin
        state_nxt_s = state_r;
        op_s        = CR_HOLD;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                if (cancel) begin
                    // Refund only if there is credit; an idle cancel is a no-op.
                    if (state_r == ST_COLLECT) begin
                        state_nxt_s = ST_CHANGE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (coin_valid_s) begin
                    if (reach_price_s) begin
                        op_s        = CR_ADD_VEND;
                        state_nxt_s = ST_VEND;
                    end else begin
                        op_s        = CR_ADD;
                        state_nxt_s = ST_COLLECT;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_VEND, ST_CHANGE: begin
                if (credit_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    op_s        = CR_SUB_UNIT;
                    state_nxt_s = ST_CHANGE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                op_s        = CR_HOLD;
            end
        endcase
    end

    // Pulse outputs for the coming cycle.
    always_comb begin
        dispense_s = 1'b0;
        change_s   = 1'b0;
        reject_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_COLLECT: begin
                dispense_s = coin_valid_s && !cancel && reach_price_s;
                reject_s   = coin_valid_s && cancel;
            end
            ST_VEND, ST_CHANGE: begin
                change_s = !credit_zero_s;
                reject_s = coin_valid_s;
            end
            default: begin
                dispense_s = 1'b0;
                change_s   = 1'b0;
                reject_s   = 1'b0;
            end
        endcase
    end

    assign dispense    = dispense_r;
    assign change_out  = change_r;
    assign coin_reject = reject_r;
    assign busy        = (state_r == ST_VEND) || (state_r == ST_CHANGE);

endmodule
